// File: rtl/backbone_pkg.sv
// Shared widths and state encodings for the GEMM backbone blocks.
package backbone_pkg;
  localparam int ACC_W       = 32;
  localparam int DRAIN_OUT_W = 16;

  typedef enum logic [1:0] {DRAIN_IDLE, DRAIN_STREAM, DRAIN_DONE} drain_state_t;

  // Index width for a counter over n items; never narrower than one bit.
  function automatic int row_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/acc_drain_quant.sv
// Per-element quantiser: arithmetic right shift, then wrap or clamp to OUT_W.
// ACC_DRAIN_SAT_EN selects clamping and adds the sat output.
module drain_quant #(
  parameter int ACC_W_P = 32,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 0
) (
  input  logic [ACC_W_P-1:0] acc,
  output logic [OUT_W-1:0]   q
`ifdef ACC_DRAIN_SAT_EN
  ,
  output logic               sat
`endif
);
`ifdef ACC_DRAIN_SAT_EN
  localparam logic signed [ACC_W_P-1:0] MAX_V = {{(ACC_W_P-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W_P-1:0] MIN_V = ~MAX_V;

  logic signed [ACC_W_P-1:0] v;
  assign v = $signed(acc) >>> SHIFT;

  always_comb begin
    sat = 1'b1;
    q   = MAX_V[OUT_W-1:0];
    if (v < MIN_V) begin
      q = MIN_V[OUT_W-1:0];
    end else if (v <= MAX_V) begin
      q   = v[OUT_W-1:0];
      sat = 1'b0;
    end
  end
`else
  assign q = OUT_W'($signed(acc) >>> SHIFT);
`endif
endmodule

// File: rtl/acc_drain.sv
// Snapshots the PE accumulator grid on start, then streams it out one row per beat.
// ACC_DRAIN_SAT_EN enables clamping quantisation and the sat_flag output.
module acc_drain
  import backbone_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int ACC_W_P = ACC_W,
  parameter int OUT_W   = DRAIN_OUT_W,
  parameter int SHIFT   = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ROWS*COLS*ACC_W_P-1:0] c_in,
  output logic                         clear_out,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [COLS*OUT_W-1:0]        m_data,
  output logic [row_w(ROWS)-1:0]       m_row,
`ifdef ACC_DRAIN_SAT_EN
  output logic                         sat_flag,
`endif
  output logic                         m_last
);
  localparam int RW = row_w(ROWS);

  logic [ROWS-1:0][COLS-1:0][ACC_W_P-1:0] c_grid, shadow_q;
  logic [COLS-1:0][ACC_W_P-1:0]           sel_row;
  logic [COLS-1:0][OUT_W-1:0]             q_row, data_q;
  logic [RW-1:0]                          row_q, row_d;
  drain_state_t                           state_q;
  logic clear_q, done_q, overrun_q, valid_q, last_q;
  logic last_row, load_beat, end_beat;

  assign c_grid   = c_in;
  assign last_row = (row_q == RW'(ROWS-1));
  assign row_d    = (state_q == DRAIN_IDLE) ? '0 : row_q + 1'b1;
  // Quantise the row that becomes visible next, so m_data is a plain register.
  assign sel_row  = (state_q == DRAIN_IDLE) ? c_grid[0] : shadow_q[row_d];

  assign load_beat = ((state_q == DRAIN_IDLE) && start) ||
                     ((state_q == DRAIN_STREAM) && m_ready && !last_row);
  assign end_beat  = (state_q == DRAIN_STREAM) && m_ready && last_row;

`ifdef ACC_DRAIN_SAT_EN
  logic [COLS-1:0] sat_v;
  logic            sat_q;
`endif

  for (genvar c = 0; c < COLS; c++) begin : g_quant
    drain_quant #(.ACC_W_P(ACC_W_P), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_quant (
      .acc (sel_row[c]),
`ifdef ACC_DRAIN_SAT_EN
      .sat (sat_v[c]),
`endif
      .q   (q_row[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DRAIN_IDLE;
      shadow_q  <= '0;
      row_q     <= '0;
      data_q    <= '0;
      clear_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      if (start && (state_q != DRAIN_IDLE)) overrun_q <= 1'b1;
      if (load_beat) begin
        data_q  <= q_row;
        valid_q <= 1'b1;
        row_q   <= row_d;
        last_q  <= (row_d == RW'(ROWS-1));
      end
      if (end_beat) begin
        data_q  <= '0;
        valid_q <= 1'b0;
        row_q   <= '0;
        last_q  <= 1'b0;
        done_q  <= 1'b1;
      end
      case (state_q)
        DRAIN_IDLE: if (start) begin
          shadow_q <= c_grid;
          clear_q  <= 1'b1;
          state_q  <= DRAIN_STREAM;
        end
        DRAIN_STREAM: if (end_beat) state_q <= DRAIN_DONE;
        default: state_q <= DRAIN_IDLE;
      endcase
    end
  end

`ifdef ACC_DRAIN_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         sat_q <= 1'b0;
    else if (load_beat) sat_q <= |sat_v;
    else if (end_beat)  sat_q <= 1'b0;
  end
  assign sat_flag = sat_q;
`endif

  assign clear_out = clear_q;
  assign busy      = (state_q != DRAIN_IDLE);
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign m_valid   = valid_q;
  assign m_data    = data_q;
  assign m_row     = row_q;
  assign m_last    = last_q;
endmodule

// File: tb/tb_acc_drain.sv
// Scoreboard bench for acc_drain: 4x4 stream instance plus a 1-row SHIFT=4 quantiser instance.
module tb_acc_drain;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, m_ready = 1'b0;
  logic [511:0] c_in = '0;
  logic         clear_out, busy, done, overrun, m_valid, m_last;
  logic [63:0]  m_data;
  logic [1:0]   m_row;
  logic         start_q = 1'b0, ready_q = 1'b0;
  logic [127:0] c_q = '0;
  logic         q_clear, q_busy, q_done, q_overrun, q_valid, q_last;
  logic [63:0]  q_data;
  logic [0:0]   q_row;
`ifdef ACC_DRAIN_SAT_EN
  logic         sat_flag, q_sat;
`endif

  always #5 clk = ~clk;

  acc_drain #(.ROWS(4), .COLS(4), .SHIFT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .c_in(c_in),
    .clear_out(clear_out), .busy(busy), .done(done), .overrun(overrun),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row),
`ifdef ACC_DRAIN_SAT_EN
    .sat_flag(sat_flag),
`endif
    .m_last(m_last));

  acc_drain #(.ROWS(1), .COLS(4), .SHIFT(4)) u_dut_q (
    .clk(clk), .rst_n(rst_n), .start(start_q), .c_in(c_q),
    .clear_out(q_clear), .busy(q_busy), .done(q_done), .overrun(q_overrun),
    .m_valid(q_valid), .m_ready(ready_q), .m_data(q_data), .m_row(q_row),
`ifdef ACC_DRAIN_SAT_EN
    .sat_flag(q_sat),
`endif
    .m_last(q_last));

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  row;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    n_tests = 0, n_fail = 0;
  int    cyc = 0, nbeats = 0, first_cyc = 0, last_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: each accepted beat is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_data", m_data, mon_e.data);
        chk("beat_row", 64'(m_row), 64'(mon_e.row));
        chk("beat_last", 64'(m_last), 64'(mon_e.last));
      end
`ifdef ACC_DRAIN_SAT_EN
      chk("beat_sat", 64'(sat_flag), 64'd0);
`endif
      nbeats = nbeats + 1;
      if (m_row == 2'd0) first_cyc = cyc;
      if (m_last) last_cyc = cyc;
    end
  end

  task automatic set_grid(input int base);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        c_in[(r*4+c)*32 +: 32] = 32'(base + 10*r + c);
  endtask

  task automatic push_tile(input int base);
    beat_t e;
    for (int r = 0; r < 4; r++) begin
      e.data = '0;
      for (int c = 0; c < 4; c++) e.data[c*16 +: 16] = 16'(base + 10*r + c);
      e.row  = 2'(r);
      e.last = (r == 3);
      exp_q.push_back(e);
    end
  endtask

  // Returns #1 after the edge that samples start.
  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("clear_pulse", 64'(clear_out), 64'd1);
    chk("valid_first", 64'(m_valid), 64'd1);
    chk("row_first", 64'(m_row), 64'd0);
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        return;
      end
    end
    chk("done_timeout", 64'd0, 64'd1);
  endtask

  int          dc;
  logic [63:0] snap;

  initial begin
    #1;
    chk("rst_ctrl", {58'd0, clear_out, busy, done, overrun, m_valid, m_last}, 64'd0);
    chk("rst_data", m_data, 64'd0);
    chk("rst_row", 64'(m_row), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic drain at full rate
    set_grid(0); push_tile(0); m_ready = 1'b1; nbeats = 0;
    do_start();
    chk("busy_stream", 64'(busy), 64'd1);
    @(posedge clk); #1;
    chk("clear_once", 64'(clear_out), 64'd0);
    wait_done(dc);
    chk("done_latency", 64'(dc - last_cyc), 64'd1);
    chk("beat_span", 64'(last_cyc - first_cyc), 64'd3);
    chk("nbeats_basic", 64'(nbeats), 64'd4);
    @(posedge clk); #1;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_valid", 64'(m_valid), 64'd0);
    chk("idle_done", 64'(done), 64'd0);

    // Backpressure on row 1
    push_tile(0); nbeats = 0;
    do_start();
    @(posedge clk); #1;
    m_ready = 1'b0;
    snap = m_data;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_data", m_data, snap);
      chk("stall_row", 64'(m_row), 64'd1);
      chk("stall_valid", 64'(m_valid), 64'd1);
    end
    m_ready = 1'b1;
    wait_done(dc);
    chk("nbeats_bp", 64'(nbeats), 64'd4);
    chk("sb_empty_bp", 64'(exp_q.size()), 64'd0);

    // Snapshot isolation and overrun
    @(posedge clk); #1;
    push_tile(0); nbeats = 0;
    do_start();
    c_in = '1;
    chk("no_overrun_yet", 64'(overrun), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("row_at_overrun", 64'(m_row), 64'd2);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("overrun_set", 64'(overrun), 64'd1);
    wait_done(dc);
    chk("nbeats_ovr", 64'(nbeats), 64'd4);
    chk("overrun_sticky", 64'(overrun), 64'd1);
    @(posedge clk); #1;
    set_grid(100); push_tile(100); nbeats = 0;
    do_start();
    wait_done(dc);
    chk("nbeats_fresh", 64'(nbeats), 64'd4);
    chk("overrun_kept", 64'(overrun), 64'd1);

    // Reset mid-stream
    @(posedge clk); #1;
    set_grid(0); push_tile(0);
    do_start();
    @(posedge clk); #1;
    m_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ctrl", {58'd0, clear_out, busy, done, overrun, m_valid, m_last}, 64'd0);
    chk("mrst_data", m_data, 64'd0);
    chk("mrst_row", 64'(m_row), 64'd0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mrst_no_done", 64'(done), 64'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    m_ready = 1'b1;
    set_grid(50); push_tile(50); nbeats = 0;
    do_start();
    wait_done(dc);
    chk("nbeats_after_rst", 64'(nbeats), 64'd4);
    chk("sb_empty_final", 64'(exp_q.size()), 64'd0);

    // Quantiser: SHIFT=4, single-row tile
    c_q[0*32 +: 32] = 32'hFFFF_FF00;   // -256
    c_q[1*32 +: 32] = 32'h0012_3450;
    c_q[2*32 +: 32] = 32'hFFF0_0000;   // -0x100000
    c_q[3*32 +: 32] = 32'h0000_0123;
    ready_q = 1'b0;
    @(posedge clk); #1 start_q = 1'b1;
    @(posedge clk); #1 start_q = 1'b0;
    chk("q_clear", 64'(q_clear), 64'd1);
    chk("q_valid", 64'(q_valid), 64'd1);
    chk("q_row", 64'(q_row), 64'd0);
    chk("q_last", 64'(q_last), 64'd1);
    chk("q_neg256", 64'(q_data[15:0]), 64'h0000_FFF0);
    chk("q_small", 64'(q_data[63:48]), 64'h0012);
`ifdef ACC_DRAIN_SAT_EN
    chk("q_clamp_hi", 64'(q_data[31:16]), 64'h7FFF);
    chk("q_clamp_lo", 64'(q_data[47:32]), 64'h8000);
    chk("q_sat_flag", 64'(q_sat), 64'd1);
`else
    chk("q_wrap_hi", 64'(q_data[31:16]), 64'h2345);
    chk("q_wrap_lo", 64'(q_data[47:32]), 64'h0000);
`endif
    ready_q = 1'b1;
    @(posedge clk); #1;
    chk("q_done", 64'(q_done), 64'd1);
    chk("q_valid_off", 64'(q_valid), 64'd0);
    @(posedge clk); #1;
    chk("q_idle", 64'(q_busy), 64'd0);
    chk("q_no_overrun", 64'(q_overrun), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/acc_drain.md
Name: acc_drain

Overview:
- Downstream stage of the 2D PE grid.
- Snapshots every PE accumulator (c_out) into a shadow bank on a single start pulse. Then pulses a clear request so the grid can begin the next tile.
- Streams the snapshot out one row per beat on a valid/ready stream, with per-element arithmetic right-shift and narrowing to OUT_W.
- Sits between the PE array and the AXI write-back path of gemm_axi.

Parameters:
- ROWS, 4, PE grid rows; number of output beats per tile.
- COLS, 4, PE grid columns; elements per beat.
- ACC_W_P, ACC_W (backbone_pkg), accumulator width per PE.
- OUT_W, DRAIN_OUT_W (backbone_pkg, 16), output element width.
- SHIFT, 0, arithmetic right-shift applied to each accumulator before narrowing; legal range 0..ACC_W_P-1.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  capture request, one-cycle pulse.
- c_in  in  ROWS*COLS*ACC_W_P  flattened accumulators, signed. Element (r,c) is at bits [(r*COLS+c)*ACC_W_P +: ACC_W_P].
- clear_out  out  1  one-cycle pulse to the grid's clear_all.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the last beat is accepted.
- overrun  out  1  sticky; set when start arrives while not in IDLE.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_data  out  COLS*OUT_W  row data; column c at [c*OUT_W +: OUT_W], signed.
- m_row  out  $clog2(ROWS) (min 1)  row index of the current beat.
- m_last  out  1  high on the beat with m_row == ROWS-1.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; shadow bank = 0; row counter = 0.
  - All outputs are 0: clear_out, busy, done, overrun, m_valid, m_data, m_row, m_last.
  - Reset mid-stream abandons the tile. No done pulse is produced.
- States: IDLE -> STREAM -> DONE -> IDLE. Encoded as drain_state_t.
- IDLE:
  - When start = 1 at edge t: shadow <= c_in, row counter <= 0, state <= STREAM.
  - clear_out = 1 for exactly the cycle after edge t.
  - The snapshot is therefore the grid value sampled at edge t, before any clear.
- STREAM:
  - m_valid = 1 from the cycle after edge t. First beat latency = 1 cycle after start.
  - m_data is driven from shadow row m_row through the quantiser. It is registered, not combinational from c_in.
  - Handshake completes when m_valid && m_ready at an edge.
  - On a handshake with m_row < ROWS-1: row counter increments.
  - On a handshake with m_row == ROWS-1: state <= DONE, m_valid <= 0.
  - While m_valid && !m_ready: m_data, m_row and m_last stay stable.
  - m_valid never deasserts before its handshake.
  - Back-to-back ready gives one beat per cycle.
- DONE: done = 1 for one cycle; state <= IDLE unconditionally.
- Start while busy (STREAM or DONE):
  - Ignored; the snapshot is not modified.
  - overrun <= 1. It clears only on reset.
- Start in the same cycle as done: ignored, overrun set. A new capture requires IDLE.
- ROWS = 1: the single beat has m_last = 1 and m_row = 0.
- Quantiser, per element:
  - v = acc >>> SHIFT (sign-preserving).
  - Without the optional feature, the result is v[OUT_W-1:0] (wrap truncation).
- Throughput: minimum tile period is ROWS + 2 cycles (capture, ROWS beats, DONE).

Optional Feature:
- Macro: ACC_DRAIN_SAT_EN.
- Defined:
  - The quantiser clamps v to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
  - Adds output sat_flag (1 bit), high on any beat where at least one element was clamped.
  - sat_flag is aligned with m_data and held under stall.
- Undefined:
  - Wrap truncation only.
  - The sat_flag port does not exist.

Decomposition:
- Add to backbone_pkg:
  - DRAIN_OUT_W = 16.
  - typedef enum logic [1:0] drain_state_t {DRAIN_IDLE, DRAIN_STREAM, DRAIN_DONE}.
- Sub-module drain_quant:
  - Combinational, one instance per column.
  - Parameters ACC_W_P, OUT_W, SHIFT.
  - in: acc; out: q, plus sat when ACC_DRAIN_SAT_EN is defined.
  - acc_drain generates COLS instances on the selected shadow row.

Test Plan:
- Basic drain: ROWS=COLS=4, SHIFT=0, c_in(r,c) = 10*r+c, start one cycle, m_ready=1.
  - clear_out pulses the next cycle.
  - Four beats on consecutive cycles: row r carries 10r+0..10r+3; m_last on row 3.
  - done one cycle after beat 3; busy low afterwards.
- Backpressure: same stimulus, m_ready low for 3 cycles during row 1.
  - Row 1 data and m_row held stable.
  - After release, rows 2 and 3 follow in order; still 4 beats total.
- Snapshot isolation: change c_in to all 0xFFFF_FFFF right after start.
  - Streamed values remain 10r+c.
- Overrun: start again during row 2.
  - overrun = 1 and stays 1; stream continues unchanged.
  - A start after done begins a fresh tile.
- Shift/narrow: SHIFT=4, acc = -256 -> q = -16.
  - acc = 0x0012_3450: without SAT, q = 0x2345; with ACC_DRAIN_SAT_EN, q = 0x7FFF and sat_flag = 1.
  - acc = -0x100000 with SAT: q = 0x8000.
- Reset mid-stream: assert rst_n low at row 1.
  - All outputs 0 immediately, no done.
  - A new start after release streams correct data.
